// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter.
// Inhibits the bus, issues a request-to-send, shifts out data/parity/stop
// on the device's falling clock edges, then checks the device ACK bit.
// Line outputs are open-drain enables: a 1 on clk_oe/data_oe pulls the line low.
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 2400,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       samplen,
   input  logic       wren,
   input  logic [7:0] d,
   output logic       clk_oe,
   output logic       data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   // One counter serves both the inhibit delay and the edge timeout; the
   // two are never active at the same time.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      BITS,
      ACK,
      WAITREL
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    clk_sync_q, data_sync_q;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          fall_ce;
   logic          line_clk;
   logic          line_data;
   logic          cnt_zero;

   // Bit 1 is the older sample; a 1 there with a 0 in bit 0 is a falling edge.
   assign line_clk  = clk_sync_q[1];
   assign line_data = data_sync_q[1];
   assign fall_ce   = samplen & clk_sync_q[1] & ~clk_sync_q[0];
   assign cnt_zero  = (cnt_q == '0);

   // Two-stage line synchronizers, advanced only on sample-enable cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (!reset_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else if (samplen) begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: every register, datapath included, is reset so a transfer cut
      // short by reset leaves nothing behind to leak into the next one.
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: the default first assignment keeps this block free of latches.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (wren) state_d = INHIBIT;
         INHIBIT: if (cnt_zero) state_d = REQ;
         REQ:     state_d = BITS;
         BITS: begin
            if (fall_ce) begin
               if (bitcnt_q == 4'd0) state_d = ACK;
            end else if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         ACK: begin
            if (fall_ce)       state_d = line_data ? IDLE : WAITREL;
            else if (cnt_zero) state_d = IDLE;
         end
         WAITREL: begin
            if (line_data && line_clk)    state_d = IDLE;
            else if (!fall_ce && cnt_zero) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (wren) begin
               // Stop bit, odd parity, then data sent LSB first.
               shift_d  = {1'b1, ~^d, d};
               cnt_d    = CW'(INHIBIT_CYCLES - 1);
               clk_oe_d = 1'b1;
            end
         end
         INHIBIT: begin
            clk_oe_d = 1'b1;
            if (cnt_zero) data_oe_d = 1'b1;
            else          cnt_d     = cnt_q - CW'(1);
         end
         REQ: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            bitcnt_d  = 4'd9;
            cnt_d     = CW'(TIMEOUT_CYCLES - 1);
         end
         BITS: begin
            if (fall_ce) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b0, shift_q[9:1]};
               bitcnt_d  = bitcnt_q - 4'd1;
               cnt_d     = CW'(TIMEOUT_CYCLES - 1);
            end else if (cnt_zero) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               error_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACK: begin
            if (fall_ce) begin
               done_d  = ~line_data;
               error_d = line_data;
               cnt_d   = CW'(TIMEOUT_CYCLES - 1);
            end else if (cnt_zero) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               error_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WAITREL: begin
            // Release seen wins over a coincident timeout: the byte was acked.
            if (line_data && line_clk) begin
               cnt_d = cnt_q;
            end else if (fall_ce) begin
               cnt_d = CW'(TIMEOUT_CYCLES - 1);
            end else if (cnt_zero) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               error_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
         end
      endcase
   end

   assign clk_oe  = clk_oe_q;
   assign data_oe = data_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: self-checking bench for ps2_tx with a behavioural PS/2 device
// on wired-AND lines and a frame model built from the protocol rules.
module tb_ps2_tx;

   localparam int INH = 8;
   localparam int TMO = 64;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic       samplen  = 1'b1;
   logic       wren     = 1'b0;
   logic [7:0] d        = 8'h00;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       clk_oe, data_oe, busy, done, error;
   logic       ps2_clk_pin, ps2_data_pin;

   // Open-drain bus: either side can pull a line low.
   assign ps2_clk_pin  = dev_clk & ~clk_oe;
   assign ps2_data_pin = dev_data & ~data_oe;

   ps2_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ps2_clk (ps2_clk_pin),
      .ps2_data(ps2_data_pin),
      .samplen (samplen),
      .wren    (wren),
      .d       (d),
      .clk_oe  (clk_oe),
      .data_oe (data_oe),
      .busy    (busy),
      .done    (done),
      .error   (error)
   );

   always #5 clk = ~clk;

   int n_checks      = 0;
   int n_errors      = 0;
   int cyc_cnt       = 0;
   int done_cnt      = 0;
   int err_cnt       = 0;
   int both_cnt      = 0;
   int err_busy_cnt  = 0;
   int last_err_cyc  = 0;
   int last_fall_cyc = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Pulse monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (error) begin
         err_cnt++;
         last_err_cyc = cyc_cnt;
         if (busy) err_busy_cnt++;
      end
      if (done && error) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected line bits as seen by the device: start, d0..d7, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = b[i];
      f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic start_tx(input logic [7:0] b);
      wren = 1'b1;
      d    = b;
      cyc(1);
      wren = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (!clk_oe && data_oe) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   // Device: clocks n_edges falling edges, samples data on each rising edge,
   // optionally pulls data low for the ACK slot, optionally pulses wren.
   task automatic dev_frame(input int n_edges, input bit ack_low, input int wr_edge,
                            input logic [7:0] wr_byte, output logic [10:0] seen);
      seen    = '0;
      seen[0] = ps2_data_pin;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack_low) dev_data = 1'b0;
         cyc(4);
         dev_clk       = 1'b0;
         last_fall_cyc = cyc_cnt;
         if (k == wr_edge) begin
            wren = 1'b1;
            d    = wr_byte;
            cyc(1);
            wren = 1'b0;
            cyc(5);
         end else begin
            cyc(6);
         end
         dev_clk = 1'b1;
         if (k <= 10) seen[k] = ps2_data_pin;
         if (k == 11) dev_data = 1'b1;
      end
   endtask

   task automatic finish_tx(input logic [7:0] b, input bit ack_low, input int wr_edge,
                            input logic [7:0] wr_byte, input int d0, input int e0);
      logic [10:0] seen;
      bit          ok;
      wait_req(ok);
      check($sformatf("req_%02h", b), ok, 1);
      dev_frame(11, ack_low, wr_edge, wr_byte, seen);
      check($sformatf("frame_%02h", b), seen, frame_of(b));
      wait_idle(ok);
      check($sformatf("idle_%02h", b), ok, 1);
      check($sformatf("lines_free_%02h", b), {clk_oe, data_oe, ps2_data_pin}, 3'b001);
      check($sformatf("done_n_%02h", b), done_cnt - d0, ack_low ? 1 : 0);
      check($sformatf("err_n_%02h", b), err_cnt - e0, ack_low ? 0 : 1);
   endtask

   task automatic run_tx(input logic [7:0] b, input bit ack_low);
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(b);
      finish_tx(b, ack_low, 0, 8'h00, d0, e0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b;
      logic [10:0] seen;
      int          n, d0, e0;
      bit          ok;

      // Asynchronous reset with no clock edge in between.
      #2 reset_n = 1'b0;
      #1;
      check("rst_outputs", {clk_oe, data_oe, busy, done, error}, 5'b00000);
      cyc(3);
      reset_n = 1'b1;
      cyc(2);
      check("idle_outputs", {clk_oe, data_oe, busy}, 3'b000);

      // 8'hED with full timing of the inhibit / start phase.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'hED);
      check("busy_after_wren", busy, 1);
      check("clk_oe_after_wren", clk_oe, 1);
      n = 0;
      while (clk_oe && !data_oe && n < 100) begin
         n++;
         cyc(1);
      end
      check("inhibit_len", n, INH);
      check("start_bit_drive", data_oe, 1);
      finish_tx(8'hED, 1'b1, 0, 8'h00, d0, e0);

      // Parity corner cases, then random bytes.
      run_tx(8'h01, 1'b1);
      run_tx(8'hFF, 1'b1);
      run_tx(8'h00, 1'b1);
      for (int i = 0; i < 4; i++) run_tx(8'($urandom), 1'b1);

      // Device NACK: data left high in the ACK slot.
      b = 8'($urandom);
      run_tx(b, 1'b0);
      check("nack_idle", {busy, clk_oe, data_oe}, 3'b000);

      // Device stops after bit 3; bit 2 is 0 so data_oe is held during the wait.
      d0 = done_cnt;
      e0 = err_cnt;
      b  = 8'($urandom) & 8'hFB;
      start_tx(b);
      wait_req(ok);
      check("to_req", ok, 1);
      dev_frame(3, 1'b0, 0, 8'h00, seen);
      check("to_bit2_driven", data_oe, 1);
      for (int i = 0; i < 200 && err_cnt == e0; i++) cyc(1);
      check("to_err_n", err_cnt - e0, 1);
      // Two edges for the synchronizer to register the fall, then the timeout.
      check("to_latency", last_err_cyc - last_fall_cyc, 2 + TMO);
      check("to_lines", {clk_oe, data_oe, busy}, 3'b000);
      check("to_no_done", done_cnt - d0, 0);

      // Write during BITS is ignored and not queued.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'h55);
      finish_tx(8'h55, 1'b1, 4, 8'hAA, d0, e0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy || clk_oe) n++;
         cyc(1);
      end
      check("no_queued_write", n, 0);

      // Reset during INHIBIT, between clock edges.
      e0 = err_cnt;
      d0 = done_cnt;
      start_tx(8'($urandom));
      cyc(3);
      check("rst_pre_inhibit", clk_oe, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_async_lines", {clk_oe, data_oe, busy}, 3'b000);
      b    = 8'($urandom);
      wren = 1'b1;
      d    = b;
      #2 reset_n = 1'b1;
      cyc(1);
      wren = 1'b0;
      check("rst_first_edge_wren", busy, 1);
      check("rst_no_pulse", (err_cnt - e0) + (done_cnt - d0), 0);
      finish_tx(b, 1'b1, 0, 8'h00, d0, e0);

      check("never_both", both_cnt, 0);
      check("err_in_idle", err_busy_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2400, clk cycles ps2_clk is held low before the start bit (100 us at 24 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 48000, the maximum number of clk cycles allowed between device clock falling edges.
REQ-003 SHALL have port: clk  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ps2_clk  input  1  PS/2 clock line as seen on the pin.
REQ-006 SHALL have port: ps2_data  input  1  PS/2 data line as seen on the pin.
REQ-007 SHALL have port: samplen  input  1  sample enable for the line synchronizers.
REQ-008 SHALL have port: wren  input  1  write strobe; starts a transfer.
REQ-009 SHALL have port: d  input  8  byte to send.
REQ-010 SHALL have port: clk_oe  output  1  1 = drive the PS/2 clock line low.
REQ-011 SHALL have port: data_oe  output  1  1 = drive the PS/2 data line low.
REQ-012 SHALL have port: busy  output  1  transfer in progress.
REQ-013 SHALL have port: done  output  1  one-cycle pulse: byte acknowledged by the device.
REQ-014 SHALL have port: error  output  1  one-cycle pulse: NACK or timeout.

Function
REQ-015 SHALL synchronize ps2_clk and ps2_data through 2-stage shift registers that advance only when samplen=1.
REQ-016 SHALL generate fall_ce, a one-cycle pulse, when the synchronized clock history reads 1 then 0 on a samplen cycle.
REQ-017 SHALL implement the states IDLE, INHIBIT, REQ, BITS, ACK and WAITREL, with IDLE as the reset state.
REQ-018 SHALL, in IDLE with wren=1, load shift[9:0] = {1, ~^d, d}, load the counter with INHIBIT_CYCLES-1, enter INHIBIT, and set busy=1 and clk_oe=1 from the next cycle.
REQ-019 SHALL, in INHIBIT, hold clk_oe=1 and decrement the counter; at counter 0 it sets data_oe=1 (start bit) and enters REQ.
REQ-020 SHALL, in REQ, clear clk_oe, hold data_oe=1, set bitcount=9, load the timeout with TIMEOUT_CYCLES-1, and enter BITS on the next cycle.
REQ-021 SHALL, in BITS on each fall_ce, set data_oe = ~shift[0], shift right by 1, decrement bitcount, and reload the timeout.
REQ-022 SHALL send data LSB first, followed by odd parity, then stop (data released).
REQ-023 SHALL, in BITS on the fall_ce with bitcount=0 (10th edge, stop bit), enter ACK.
REQ-024 SHALL, in ACK on fall_ce, check the synchronized data line: if 0, pulse done and enter WAITREL; if 1, pulse error and enter IDLE.
REQ-025 SHALL, in WAITREL, enter IDLE once synchronized ps2_data=1 and ps2_clk=1 are sampled.
REQ-026 SHALL, in BITS, ACK and WAITREL, decrement the timeout on each cycle without fall_ce; at 0 it sets clk_oe=0 and data_oe=0, pulses error, and enters IDLE.
REQ-027 SHALL ignore wren while busy=1, with no latching and no queuing.
REQ-028 SHALL hold busy=1 in every state except IDLE, and set busy=0 in the cycle it enters IDLE.
REQ-029 SHALL never assert done and error together.
REQ-030 SHALL keep data_oe=0 and clk_oe=0 in IDLE.

Reset
REQ-031 SHALL, while reset_n=0, immediately force state=IDLE and clk_oe=data_oe=busy=done=error=0, regardless of clk.
REQ-032 SHALL, after reset mid-transfer, release both lines asynchronously, discard the partial byte, and emit neither done nor error.
REQ-033 SHALL, after reset_n deasserts, accept wren on the first clk edge.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64, samplen=1)
REQ-034 SHALL cover: d=8'hED, wren pulse, device model clocks 11 falling edges and drives ACK=0 -> clk_oe high for 8 cycles, then start bit 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen on the line; done pulses once; busy drops after the line is released.
REQ-035 SHALL cover: d=8'h01 -> parity bit 0; d=8'hFF -> parity bit 1; d=8'h00 -> parity bit 1.
REQ-036 SHALL cover: device leaves data high in the ACK slot -> error pulses once, no done, IDLE next cycle.
REQ-037 SHALL cover: device stops clocking after bit 3 -> exactly 64 cycles after the last fall_ce, clk_oe=data_oe=0 and error pulses.
REQ-038 SHALL cover: wren=1 with d=8'hAA during BITS while sending 8'h55 -> the transmitted byte stays 8'h55 and the 8'hAA write is not sent later.
REQ-039 SHALL cover: reset_n low during INHIBIT -> clk_oe=0 without waiting for a clk edge, busy=0, no error pulse.
